// File: rtl/rol4_pkg.sv
// Shared definitions for the sequential shift/rotate unit: FSM states and width constants.
package rol4_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int AMT_W     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/rol1_step.sv
// Combinational single-bit left step: zero fill in logical mode, MSB wraps to LSB in rotate mode.
module rol1_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic             rot,
    output logic [WIDTH-1:0] stepped,
    output logic             msb
);

    assign msb     = data[WIDTH-1];
    assign stepped = {data[WIDTH-2:0], rot & data[WIDTH-1]};

endmodule

// File: rtl/rol4_seq.sv
// Multi-cycle left shift/rotate: one bit per cycle, done pulses one cycle after the last step.
module rol4_seq
    import rol4_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [AMT_W-1:0] s,
    input  logic             rot,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] count;
    logic             mode;
    logic [WIDTH-1:0] stepped;
    logic             msb;

    rol1_step #(.WIDTH(WIDTH)) u_step (
        .data    (data),
        .rot     (mode),
        .stepped (stepped),
        .msb     (msb)
    );

    assign out = data;

    // busy and done are registered alongside the state so they never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            count <= '0;
            mode  <= 1'b0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        data  <= in;
                        count <= s;
                        mode  <= rot;
                        carry <= 1'b0;
                        busy  <= 1'b1;
                        if (s == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data  <= stepped;
                    carry <= msb;
                    count <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rol4_seq.sv
// Self-checking bench for rol4_seq: directed cases plus randomized operations against an arithmetic model.
module tb_rol4_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in;
    logic [1:0]   s;
    logic         rot;
    logic [W-1:0] out;
    logic         carry;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    rol4_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in),
        .s     (s),
        .rot   (rot),
        .out   (out),
        .carry (carry),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Reference: whole-word arithmetic shift/rotate, carry is the last bit pushed out of the top
    function automatic void refModel(input int a, input int amt, input bit r,
                                     output int res, output int cy);
        int full;
        full = a << amt;
        if (r)
            res = (full | (a >> (W - amt))) & ((1 << W) - 1);
        else
            res = full & ((1 << W) - 1);
        cy = (amt == 0) ? 0 : ((a >> (W - amt)) & 1);
    endfunction

    // Called just after a rising edge; accepts at the next edge and follows the op to IDLE
    task automatic applyStimulus(input logic [W-1:0] a, input logic [1:0] amt,
                                 input logic r, input bit perturb);
        int exp_res, exp_cy, cycles;
        refModel(int'(a), int'(amt), r, exp_res, exp_cy);
        start = 1'b1;
        in    = a;
        s     = amt;
        rot   = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_accept", int'(busy), 1);
        if (perturb) begin
            start = 1'b1;
            in    = '0;
            s     = ~amt;
            rot   = ~r;
        end
        cycles = 0;
        while (!done && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("done_seen", int'(done), 1);
        checkOutput("latency", cycles, int'(amt));
        checkOutput("result", int'(out), exp_res);
        checkOutput("carry", int'(carry), exp_cy);
        checkOutput("busy_in_done", int'(busy), 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("done_pulse_end", int'(done), 0);
        checkOutput("busy_idle", int'(busy), 0);
        checkOutput("result_hold", int'(out), exp_res);
        checkOutput("carry_hold", int'(carry), exp_cy);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        in    = '0;
        s     = '0;
        rot   = 1'b0;
        #1;
        checkOutput("reset_out", int'(out), 0);
        checkOutput("reset_carry", int'(carry), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(4'b1011, 2'd2, 1'b0, 1'b0);
        applyStimulus(4'b1011, 2'd3, 1'b1, 1'b0);
        applyStimulus(4'b1001, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b1011, 2'd3, 1'b1, 1'b1);
        applyStimulus(4'b1000, 2'd1, 1'b0, 1'b0);

        // Abort mid-SHIFT: outputs must clear before the next edge and no done may follow
        start = 1'b1;
        in    = 4'b1111;
        s     = 2'd3;
        rot   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_out", int'(out), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_carry", int'(carry), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_done", int'(done), 0);
        end
        rst = 1'b0;
        applyStimulus(4'b0001, 2'd1, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(4'($urandom), 2'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rol4_seq.md
ROL4_SEQ -- requirements
Module: rol4_seq

Interface
REQ-001 Parameter: WIDTH, default 4, data width; AMT_W fixed at 2, shift-amount width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 in  input  WIDTH  operand, captured when start is accepted.
REQ-006 s  input  AMT_W  left-shift amount 0..3, captured when start is accepted.
REQ-007 rot  input  1  mode, captured when start is accepted: 0 = logical shift left with zero fill, 1 = rotate left.
REQ-008 out  output  WIDTH  registered result; holds value until the next accepted start.
REQ-009 carry  output  1  MSB shifted out by the final single-bit step; 0 when s = 0.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse marking out/carry valid.

Function
REQ-012 The block SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 In IDLE with start = 1 at an edge, the block SHALL load in into the data register, s into a down-counter and rot into a mode register, and clear carry.
REQ-014 On acceptance, the next state SHALL be DONE if s = 0, otherwise SHIFT.
REQ-015 Each edge in SHIFT SHALL perform one single-bit left step per the mode, set carry to the pre-step MSB, and decrement the counter.
REQ-016 When the counter equals 1 at a SHIFT edge, the next state SHALL be DONE; otherwise SHIFT.
REQ-017 Timing: the start-accepting edge is E0. done SHALL be high for exactly the one cycle following edge E(s), with E(0) = E0. Latency is therefore s+1 cycles from start to done.
REQ-018 The DONE state SHALL always return to IDLE on the next edge.
REQ-019 start SHALL be ignored while busy = 1, including the DONE cycle. Captured operands SHALL NOT change.
REQ-020 A start in the first IDLE cycle after DONE SHALL be accepted, so back-to-back operations incur no dead cycle beyond DONE.
REQ-021 out SHALL show the data register at all times. Intermediate values during SHIFT are allowed, but out SHALL equal the final result from the done cycle until the next accepted start.
REQ-022 Arithmetic: all results SHALL be mod 2^WIDTH. Logical mode SHALL discard shifted-out bits. Rotate mode SHALL feed the MSB into the LSB.

Reset
REQ-023 rst = 1 SHALL immediately, without waiting for a clock edge, force state IDLE, out = 0, carry = 0, busy = 0, done = 0, counter = 0 and mode = 0.
REQ-024 Reset asserted mid-operation SHALL abort that operation with no done pulse. The first edge after rst deasserts SHALL accept start normally.

Structure
REQ-025 A shared package rol4_pkg SHALL hold the state enumeration (IDLE, SHIFT, DONE), the WIDTH default and the AMT_W constant.
REQ-026 One combinational sub-module, rol1_step, SHALL perform the single-bit step. Inputs: data, rot. Outputs: stepped data, shifted-out MSB.
REQ-027 The FSM, counter and registers SHALL reside in rol4_seq. No other sub-modules.

Verification
REQ-028 in = 1011, s = 2, rot = 0, start at E0 -> done in the cycle after E2, out = 1100, carry = 0, busy high E0..E3.
REQ-029 in = 1011, s = 3, rot = 1 -> done in the cycle after E3, out = 1101, carry = 1.
REQ-030 in = 1001, s = 0, rot = 0 -> done in the cycle after E0, out = 1001, carry = 0.
REQ-031 During an s = 3 run, assert start with in = 0000 in the SHIFT and DONE cycles -> ignored; result is unchanged from the unperturbed run.
REQ-032 Assert rst mid-SHIFT -> out = 0, busy = 0, done = 0 with no clock edge, and no done pulse follows. After release, in = 0001, s = 1, rot = 0 -> out = 0010.
REQ-033 Back-to-back: a second start in the first IDLE cycle after done, with in = 1000, s = 1, rot = 0 -> accepted, out = 0000, carry = 1.
